aha_reset_handshake_ctrl: RTL and testbench

AHA_RESET_HANDSHAKE_CTRL -- requirements
Module: aha_reset_handshake_ctrl

---
 rtl/aha_reset_handshake_ctrl_if.sv | 25 ++
 rtl/aha_reset_handshake_ctrl.sv | 178 +++++++++++++++++
 tb/tb_aha_reset_handshake_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aha_reset_handshake_ctrl_if.sv
// Register bus plus per-channel reset request/acknowledge for aha_reset_handshake_ctrl.
// Single-cycle strobes with no backpressure; acks may arrive asynchronously.
interface aha_reset_handshake_ctrl_if #(
    parameter int NUM_CH = 11
);
    logic [11:0]       reg_addr;
    logic              reg_read_en;
    logic              reg_write_en;
    logic [3:0]        reg_byte_strobe;
    logic [31:0]       reg_wdata;
    logic [31:0]       reg_rdata;
    logic [NUM_CH-1:0] rst_ack_i;
    logic [NUM_CH-1:0] rst_req_o;
    logic              irq_o;

    modport master (
        output reg_addr, reg_read_en, reg_write_en, reg_byte_strobe, reg_wdata, rst_ack_i,
        input  reg_rdata, rst_req_o, irq_o
    );

    modport slave (
        input  reg_addr, reg_read_en, reg_write_en, reg_byte_strobe, reg_wdata, rst_ack_i,
        output reg_rdata, rst_req_o, irq_o
    );
endinterface

// File: rtl/aha_reset_handshake_ctrl.sv
// Per-channel reset request/acknowledge sequencer with timeout and sticky status registers.
// Request rises the cycle after a START write; reads are combinational; no backpressure.
module aha_reset_handshake_ctrl #(
    parameter int NUM_CH    = 11,
    parameter int TIMEOUT_W = 8
) (
    input logic                      clk,
    input logic                      reset,
    aha_reset_handshake_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam logic [4:0] OFF_START     = 5'd0;
    localparam logic [4:0] OFF_DONE      = 5'd1;
    localparam logic [4:0] OFF_TMO       = 5'd2;
    localparam logic [4:0] OFF_IRQ_EN    = 5'd3;
    localparam logic [4:0] OFF_TMO_LIMIT = 5'd4;
    localparam logic [4:0] OFF_ACK_RAW   = 5'd5;

    logic [4:0]           off;
    logic [31:0]          bmask;
    logic [31:0]          wbits;
    logic                 unused_bits;

    logic [NUM_CH-1:0]    ack_meta_q;
    logic [NUM_CH-1:0]    ack_s_q;

    state_t               state_q [NUM_CH];
    state_t               state_d [NUM_CH];
    logic [TIMEOUT_W-1:0] cnt_q   [NUM_CH];
    logic [TIMEOUT_W-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0]    req_q, req_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic [NUM_CH-1:0]    tmo_q, tmo_d;
    logic [NUM_CH-1:0]    irq_en_q, irq_en_d;
    logic [TIMEOUT_W-1:0] tmo_limit_q, tmo_limit_d;
    logic                 irq_q, irq_d;

    logic [NUM_CH-1:0]    start_set;
    logic [NUM_CH-1:0]    done_set, tmo_set;
    logic [NUM_CH-1:0]    done_clr, tmo_clr;
    logic [NUM_CH-1:0]    tmo_hit;
    logic [NUM_CH-1:0]    busy;
    logic [31:0]          rdata;

    assign off   = bus.reg_addr[6:2];
    assign bmask = {{8{bus.reg_byte_strobe[3]}}, {8{bus.reg_byte_strobe[2]}},
                    {8{bus.reg_byte_strobe[1]}}, {8{bus.reg_byte_strobe[0]}}};
    assign wbits = bus.reg_wdata & bmask;
    assign unused_bits = ^{bus.reg_addr[11:7], bus.reg_addr[1:0], wbits, bmask};

    assign start_set = (bus.reg_write_en && off == OFF_START) ? wbits[NUM_CH-1:0] : '0;
    assign done_clr  = (bus.reg_write_en && off == OFF_DONE)  ? wbits[NUM_CH-1:0] : '0;
    assign tmo_clr   = (bus.reg_write_en && off == OFF_TMO)   ? wbits[NUM_CH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_meta_q <= '0;
            ack_s_q    <= '0;
        end else begin
            ack_meta_q <= bus.rst_ack_i;
            ack_s_q    <= ack_meta_q;
        end
    end

    always_comb begin
        tmo_hit = '0;
        busy    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            tmo_hit[ch] = (tmo_limit_q != '0) && (cnt_q[ch] == tmo_limit_q);
            busy[ch]    = (state_q[ch] != ST_IDLE);
        end
    end

    // Exit condition is tested before the timeout so a late ack still completes cleanly.
    always_comb begin
        done_set = '0;
        tmo_set  = '0;
        req_d    = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            state_d[ch] = state_q[ch];
            cnt_d[ch]   = cnt_q[ch];
            case (state_q[ch])
                ST_IDLE: begin
                    if (start_set[ch]) begin
                        state_d[ch] = ST_REQ;
                        cnt_d[ch]   = '0;
                    end
                end
                ST_REQ: begin
                    if (ack_s_q[ch]) begin
                        state_d[ch] = ST_REL;
                        cnt_d[ch]   = '0;
                    end else if (tmo_hit[ch]) begin
                        state_d[ch] = ST_IDLE;
                        tmo_set[ch] = 1'b1;
                    end else if (cnt_q[ch] != '1) begin
                        cnt_d[ch] = cnt_q[ch] + TIMEOUT_W'(1);
                    end
                end
                ST_REL: begin
                    if (!ack_s_q[ch]) begin
                        state_d[ch]  = ST_IDLE;
                        done_set[ch] = 1'b1;
                    end else if (tmo_hit[ch]) begin
                        state_d[ch] = ST_IDLE;
                        tmo_set[ch] = 1'b1;
                    end else if (cnt_q[ch] != '1) begin
                        cnt_d[ch] = cnt_q[ch] + TIMEOUT_W'(1);
                    end
                end
                default: state_d[ch] = ST_IDLE;
            endcase
            req_d[ch] = (state_d[ch] == ST_REQ);
        end
    end

    always_comb begin
        done_d      = (done_q & ~done_clr) | done_set;
        tmo_d       = (tmo_q & ~tmo_clr) | tmo_set;
        irq_en_d    = irq_en_q;
        tmo_limit_d = tmo_limit_q;
        if (bus.reg_write_en && off == OFF_IRQ_EN)
            irq_en_d = (irq_en_q & ~bmask[NUM_CH-1:0]) | wbits[NUM_CH-1:0];
        if (bus.reg_write_en && off == OFF_TMO_LIMIT)
            tmo_limit_d = (tmo_limit_q & ~bmask[TIMEOUT_W-1:0]) | wbits[TIMEOUT_W-1:0];
        irq_d = |((done_q | tmo_q) & irq_en_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= ST_IDLE;
                cnt_q[ch]   <= '0;
            end
            req_q       <= '0;
            done_q      <= '0;
            tmo_q       <= '0;
            irq_en_q    <= '0;
            tmo_limit_q <= '1;
            irq_q       <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                state_q[ch] <= state_d[ch];
                cnt_q[ch]   <= cnt_d[ch];
            end
            req_q       <= req_d;
            done_q      <= done_d;
            tmo_q       <= tmo_d;
            irq_en_q    <= irq_en_d;
            tmo_limit_q <= tmo_limit_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (bus.reg_read_en) begin
            case (off)
                OFF_START:     rdata[NUM_CH-1:0]    = busy;
                OFF_DONE:      rdata[NUM_CH-1:0]    = done_q;
                OFF_TMO:       rdata[NUM_CH-1:0]    = tmo_q;
                OFF_IRQ_EN:    rdata[NUM_CH-1:0]    = irq_en_q;
                OFF_TMO_LIMIT: rdata[TIMEOUT_W-1:0] = tmo_limit_q;
                OFF_ACK_RAW:   rdata[NUM_CH-1:0]    = ack_s_q;
                default:       rdata                = '0;
            endcase
        end
    end

    assign bus.reg_rdata = rdata;
    assign bus.rst_req_o = req_q;
    assign bus.irq_o     = irq_q;
endmodule

// File: tb/tb_aha_reset_handshake_ctrl.sv
// Directed bench for aha_reset_handshake_ctrl: nominal, timeout, W1C collision,
// concurrency, byte strobes and mid-handshake reset, with hand-computed expectations.
module tb_aha_reset_handshake_ctrl;
    localparam logic [11:0] A_START = 12'h000;
    localparam logic [11:0] A_DONE  = 12'h004;
    localparam logic [11:0] A_TMO   = 12'h008;
    localparam logic [11:0] A_IRQEN = 12'h00C;
    localparam logic [11:0] A_LIMIT = 12'h010;
    localparam logic [11:0] A_ACK   = 12'h014;
    localparam logic [11:0] A_UNMAP = 12'h018;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    aha_reset_handshake_ctrl_if #(.NUM_CH(11)) bus ();

    aha_reset_handshake_ctrl #(.NUM_CH(11), .TIMEOUT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] strb);
        bus.reg_addr        = a;
        bus.reg_wdata       = d;
        bus.reg_byte_strobe = strb;
        bus.reg_write_en    = 1'b1;
        tick();
        bus.reg_write_en    = 1'b0;
        bus.reg_wdata       = '0;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.reg_addr    = a;
        bus.reg_read_en = 1'b1;
        #1;
        d = bus.reg_rdata;
        bus.reg_read_en = 1'b0;
        check(tag, d, exp);
    endtask

    initial begin
        reset               = 1'b1;
        bus.reg_addr        = '0;
        bus.reg_read_en     = 1'b0;
        bus.reg_write_en    = 1'b0;
        bus.reg_byte_strobe = '0;
        bus.reg_wdata       = '0;
        bus.rst_ack_i       = '0;
        tick();
        tick();
        check("rst_req_reset", 32'(bus.rst_req_o), 32'h0);
        check("irq_reset", 32'(bus.irq_o), 32'h0);
        chk_rd("limit_reset", A_LIMIT, 32'h0000_00FF);
        reset = 1'b0;
        tick();
        chk_rd("done_reset", A_DONE, 32'h0);
        chk_rd("start_reset", A_START, 32'h0);

        // Nominal handshake on channel 0
        wr(A_START, 32'h1, 4'hF);
        check("nom_req_T1", 32'(bus.rst_req_o), 32'h1);
        chk_rd("nom_busy", A_START, 32'h1);
        tick(); tick(); tick();
        bus.rst_ack_i[0] = 1'b1;
        tick(); tick();
        check("nom_req_T5", 32'(bus.rst_req_o), 32'h1);
        tick();
        check("nom_req_T6", 32'(bus.rst_req_o), 32'h0);
        chk_rd("nom_busy_rel", A_START, 32'h1);
        tick(); tick(); tick(); tick();
        bus.rst_ack_i[0] = 1'b0;
        tick(); tick();
        chk_rd("nom_done_T12", A_DONE, 32'h0);
        tick();
        chk_rd("nom_done_T13", A_DONE, 32'h1);
        chk_rd("nom_idle", A_START, 32'h0);
        check("nom_irq", 32'(bus.irq_o), 32'h0);
        wr(A_DONE, 32'h1, 4'hF);
        chk_rd("nom_done_clr", A_DONE, 32'h0);

        // Timeout on channel 2
        wr(A_LIMIT, 32'h4, 4'hF);
        wr(A_IRQEN, 32'h4, 4'hF);
        wr(A_START, 32'h4, 4'hF);
        tick(); tick(); tick(); tick();
        check("tmo_req_E4", 32'(bus.rst_req_o), 32'h4);
        tick();
        check("tmo_req_E5", 32'(bus.rst_req_o), 32'h0);
        chk_rd("tmo_sticky", A_TMO, 32'h4);
        chk_rd("tmo_done0", A_DONE, 32'h0);
        check("tmo_irq_E5", 32'(bus.irq_o), 32'h0);
        tick();
        check("tmo_irq_E6", 32'(bus.irq_o), 32'h1);
        wr(A_TMO, 32'h4, 4'hF);
        chk_rd("tmo_clr", A_TMO, 32'h0);
        check("tmo_irq_E7", 32'(bus.irq_o), 32'h1);
        tick();
        check("tmo_irq_E8", 32'(bus.irq_o), 32'h0);
        wr(A_LIMIT, 32'hFF, 4'hF);

        // DONE set colliding with W1C on the same edge
        wr(A_IRQEN, 32'h1, 4'hF);
        wr(A_START, 32'h1, 4'hF);
        bus.rst_ack_i[0] = 1'b1;
        tick(); tick(); tick();
        check("col_req_rel", 32'(bus.rst_req_o), 32'h0);
        bus.rst_ack_i[0] = 1'b0;
        tick(); tick();
        wr(A_DONE, 32'h1, 4'hF);
        chk_rd("col_set_wins", A_DONE, 32'h1);
        chk_rd("col_idle", A_START, 32'h0);
        tick();
        check("col_irq_on", 32'(bus.irq_o), 32'h1);
        wr(A_DONE, 32'h1, 4'hF);
        chk_rd("col_done_clr", A_DONE, 32'h0);
        check("col_irq_lag", 32'(bus.irq_o), 32'h1);
        tick();
        check("col_irq_off", 32'(bus.irq_o), 32'h0);

        // All channels with staggered acks; rewrite while busy is ignored
        wr(A_IRQEN, 32'h0, 4'hF);
        wr(A_START, 32'h7FF, 4'hF);
        check("all_req", 32'(bus.rst_req_o), 32'h7FF);
        for (int i = 0; i < 11; i++) begin
            bus.rst_ack_i[i] = 1'b1;
            tick();
        end
        tick(); tick(); tick();
        check("all_rel", 32'(bus.rst_req_o), 32'h0);
        chk_rd("all_busy", A_START, 32'h7FF);
        wr(A_START, 32'h7FF, 4'hF);
        check("rewrite_req", 32'(bus.rst_req_o), 32'h0);
        chk_rd("rewrite_busy", A_START, 32'h7FF);
        bus.rst_ack_i[0] = 1'b0;
        tick(); tick(); tick();
        chk_rd("ch0_alone", A_DONE, 32'h001);
        chk_rd("ch0_idle", A_START, 32'h7FE);
        for (int i = 1; i < 11; i++) begin
            bus.rst_ack_i[i] = 1'b0;
            tick();
        end
        tick(); tick(); tick();
        chk_rd("all_done", A_DONE, 32'h7FF);
        chk_rd("all_idle", A_START, 32'h0);
        check("all_req_end", 32'(bus.rst_req_o), 32'h0);
        wr(A_DONE, 32'hFFFF_FFFF, 4'hF);
        chk_rd("all_done_clr", A_DONE, 32'h0);

        // Byte strobes, unmapped offsets, disabled read
        wr(A_LIMIT, 32'hFFFF_FF10, 4'h2);
        chk_rd("strb_ignored", A_LIMIT, 32'h0000_00FF);
        wr(A_LIMIT, 32'h0000_0A33, 4'h1);
        chk_rd("strb_byte0", A_LIMIT, 32'h0000_0033);
        wr(A_LIMIT, 32'hFF, 4'hF);
        chk_rd("unmapped", A_UNMAP, 32'h0);
        wr(A_IRQEN, 32'hFFFF_FFFF, 4'hF);
        chk_rd("irqen_mask", A_IRQEN, 32'h0000_07FF);
        wr(A_IRQEN, 32'h0, 4'hF);
        bus.reg_addr = A_LIMIT;
        #1;
        check("rdata_no_rd", bus.reg_rdata, 32'h0);
        bus.rst_ack_i = 11'h005;
        tick(); tick();
        chk_rd("ack_raw", A_ACK, 32'h005);
        bus.rst_ack_i = '0;
        tick(); tick();

        // Reset in the middle of a handshake
        wr(A_START, 32'h2, 4'hF);
        check("mid_req", 32'(bus.rst_req_o), 32'h2);
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_async", 32'(bus.rst_req_o), 32'h0);
        check("mid_rst_irq", 32'(bus.irq_o), 32'h0);
        reset = 1'b0;
        tick();
        chk_rd("mid_start", A_START, 32'h0);
        chk_rd("mid_done", A_DONE, 32'h0);
        chk_rd("mid_tmo", A_TMO, 32'h0);
        chk_rd("mid_limit", A_LIMIT, 32'h0000_00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
